// File: rtl/click_sync_sink.sv
// click_sync_sink: terminates a 2-phase bundled-data click pipeline into the i_clk domain.
// Latency: in_reqL toggle -> push/out_ackL toggle at edge SYNC_STAGES+1; o_valid follows the same edge.
// Backpressure: a full FIFO holds the pending token (no ack, no capture) until an entry drains.
//
// Ports: i_clk/i_rstn (async active-low); in_reqL/in_dataL/out_ackL = click side;
//        o_valid/o_data/i_ready = consumer stream; o_full = FIFO holds DEPTH entries;
//        o_xfer_cnt = 16-bit wrapping push counter, present only when CLICK_SINK_CNT_EN is defined.
// Parameters: DW data width, SYNC_STAGES (2..3) request synchronizer depth, DEPTH (power of 2, >=2).
module click_sync_sink #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 2
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          in_reqL,
  input  logic [DW-1:0] in_dataL,
  output logic          out_ackL,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  input  logic          i_ready,
  output logic          o_full
`ifdef CLICK_SINK_CNT_EN
  ,
  output logic [15:0]   o_xfer_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ack_q, ack_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DW-1:0]          mem_q [DEPTH];
  logic [DW-1:0]          mem_d [DEPTH];

  logic req_s;
  logic pending;
  logic full;
  logic push;
  logic pop;

  // Only the first sync flop ever sees the raw asynchronous request.
  assign req_s   = sync_q[SYNC_STAGES-1];
  assign pending = req_s ^ ack_q;
  assign full    = (cnt_q == CW'(DEPTH));
  // Push is gated on the count at cycle start, so a same-cycle pop never lets a push in.
  assign push    = pending & ~full;
  assign pop     = (cnt_q != '0) & i_ready;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], in_reqL};
    ack_d    = ack_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_dataL;
      wr_ptr_d        = wr_ptr_q + AW'(1);
      // Toggling ack makes req_s == ack again, which rules out a second capture.
      ack_d           = ~ack_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_q   <= '0;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sync_q   <= sync_d;
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

  assign out_ackL = ack_q;
  assign o_valid  = (cnt_q != '0);
  assign o_full   = full;
  assign o_data   = mem_q[rd_ptr_q];

`ifdef CLICK_SINK_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (push) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign o_xfer_cnt = xfer_cnt_q;
`endif

endmodule
